battle_grid_engine: RTL and testbench
=====================================

Name: battle_grid_engine

Overview:
- Parametrised successor to the game grid engine: holds two battleship boards (player, IA) in registers.
- Executes place/shoot/clear commands over a valid/ready handshake, with one response pulse per command.
- Provides a registered pixel-to-cell status lookup for the VGA renderer.
- Sits between the game-control FSM / mouse decoder and the display pipeline.

Parameters:
- GRID_W, 10, board columns (2..16)
- GRID_H, 10, board rows (2..16)
- COORD_W, 10, pixel coordinate width
- CELL_SHIFT, 5, log2 of cell size in pixels (cell = 32 px)
- ORIGIN_X, 0, pixel x of the board's left edge
- ORIGIN_Y, 0, pixel y of the board's top edge
- MAX_SHIP, 5, maximum ship length accepted
- CNT_W, 7, width of the ship-cell and hit counters

Ports:
- clk_in  in  1  system clock
- rst_n_in  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  engine idle, command accepted when valid&ready
- cmd_op  in  2  0=NOP, 1=PLACE, 2=SHOOT, 3=CLEAR
- cmd_board  in  1  0=player board, 1=IA board
- cmd_x  in  4  cell column
- cmd_y  in  4  cell row
- cmd_dir  in  1  0=horizontal (+x), 1=vertical (+y)
- cmd_len  in  3  ship length (PLACE only)
- rsp_valid  out  1  one-cycle response pulse
- rsp_code  out  3  0=OK, 1=OOB, 2=COLLIDE, 3=BADLEN, 4=HIT, 5=MISS, 6=ALREADY
- pix_x  in  COORD_W  render pixel x
- pix_y  in  COORD_W  render pixel y
- pix_board  in  1  board selected for render
- pix_status  out  2  status of the cell under the pixel
- pix_in_grid  out  1  pixel lies inside the board
- ship_cells_p  out  CNT_W  ship cells placed, player board
- ship_cells_ia  out  CNT_W  ship cells placed, IA board
- hits_p  out  CNT_W  hits on the player board
- hits_ia  out  CNT_W  hits on the IA board
- sunk_p  out  1  all player ships sunk
- sunk_ia  out  1  all IA ships sunk

Behaviour:
- Cell encoding (2 bits): FREE=0, SHIP=1, MISS=2, HIT=3.
- Reset (async, rst_n_in low):
  - all cells FREE, counters 0, FSM to IDLE
  - cmd_ready=1, rsp_valid=0, rsp_code=0, pix_status=0, pix_in_grid=0
  - reset mid-command aborts the command immediately; no response is issued.
- FSM states: IDLE, CHECK, WRITE, SHOOT, CLEAR, RESP.
  - cmd_ready=1 only in IDLE.
  - Accept in IDLE latches all cmd_* fields and an index counter i=0.
- NOP: IDLE to RESP with code OK.
- PLACE:
  - BADLEN if cmd_len==0 or cmd_len>MAX_SHIP.
  - OOB if the end cell (x+len-1 or y+len-1) >= GRID_W/GRID_H, or if x/y itself is out of range.
  - Both are checked at accept; on either, go to RESP (latency 1).
  - Otherwise CHECK visits one cell per cycle (i=0..len-1).
    - Any non-FREE cell: go to RESP with COLLIDE; no cell is modified.
  - After the last cell passes, WRITE sets one cell per cycle to SHIP.
  - Then ship_cells for the selected board += len, and RESP with OK.
  - Total latency, accept to rsp_valid: 2*len+1 cycles.
- SHOOT:
  - Out-of-range coordinates give OOB.
  - Otherwise a single SHOOT cycle:
    - SHIP: becomes HIT, hits+=1, code HIT
    - FREE: becomes MISS, code MISS
    - MISS or HIT: unchanged, code ALREADY
  - Response follows in RESP (latency 2).
- CLEAR:
  - Sweeps one row per cycle (GRID_H cycles), writing FREE to the selected board only.
  - Zeroes that board's counters, then RESP with OK.
- RESP:
  - rsp_valid=1 for exactly one cycle; rsp_code holds its value until the next response.
  - Returns to IDLE; the next command can be accepted the following cycle.
- sunk_x = (ship_cells_x != 0) && (hits_x == ship_cells_x). This is combinational from the counters.
- Counters saturate at 2^CNT_W-1.
- Render lookup:
  - cx = (pix_x-ORIGIN_X)>>CELL_SHIFT, cy likewise.
  - pix_in_grid = pix_x>=ORIGIN_X && cx<GRID_W, and likewise for y.
  - Outputs are registered, 1-cycle latency, and reflect cell state as of the prior clock edge.
  - pix_status=0 when out of grid.
  - The render read is concurrent with commands; no arbitration.

Decomposition:
- Package grid_pkg: cell encodings, cmd_op encodings, rsp_code encodings, FSM state enum.
- Sub-module grid_pix_map: pixel to (cx, cy, in_grid) combinational mapper, instantiated once in the render path.

Test Plan:
- Reset then PLACE board0 (2,3) horiz len3 → rsp OK after 7 cycles; cells (2..4,3)=SHIP; ship_cells_p=3.
- PLACE board0 (3,1) vert len4 over the previous ship → COLLIDE, cell (3,1) stays FREE, ship_cells_p stays 3; PLACE (8,0) horiz len3 → OOB after 1 cycle; len 0 → BADLEN.
- SHOOT board0 (2,3) → HIT, hits_p=1; SHOOT (2,3) again → ALREADY; SHOOT (0,0) → MISS, cell=2.
- Sink the 3-cell ship → sunk_p=1 and sunk_ia=0; CLEAR board0 → all cells FREE after GRID_H+1 cycles, counters 0, sunk_p=0.
- pix_x=70, pix_y=100, pix_board=0 → pix_status of cell (2,3), 1 cycle later; pix_x=330 → pix_in_grid=0, pix_status=0.
- Assert rst_n_in low during WRITE of a len5 place → no rsp_valid; after release, board empty and cmd_ready=1.

Source files
------------

// File: rtl/grid_pkg.sv
// Shared encodings for the battle grid engine: cell states, command opcodes,
// response codes and the command FSM states.
package grid_pkg;

    typedef enum logic [1:0] {
        CellFree = 2'd0,
        CellShip = 2'd1,
        CellMiss = 2'd2,
        CellHit  = 2'd3
    } cell_e;

    typedef enum logic [1:0] {
        OpNop   = 2'd0,
        OpPlace = 2'd1,
        OpShoot = 2'd2,
        OpClear = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        RspOk      = 3'd0,
        RspOob     = 3'd1,
        RspCollide = 3'd2,
        RspBadlen  = 3'd3,
        RspHit     = 3'd4,
        RspMiss    = 3'd5,
        RspAlready = 3'd6
    } rsp_e;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StWrite,
        StShoot,
        StClear,
        StResp
    } state_e;

endpackage

// File: rtl/grid_pix_map.sv
// Maps a render pixel coordinate onto a board cell column/row plus an
// in-grid flag. Purely combinational.
module grid_pix_map #(
    parameter int COORD_W    = 10,
    parameter int CELL_SHIFT = 5,
    parameter int ORIGIN_X   = 0,
    parameter int ORIGIN_Y   = 0,
    parameter int GRID_W     = 10,
    parameter int GRID_H     = 10
) (
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    output logic [3:0]         cx,
    output logic [3:0]         cy,
    output logic               in_grid
);

    logic [COORD_W-1:0] dx, dy, cx_full, cy_full;
    logic               in_x, in_y;

    always_comb begin
        dx      = pix_x - COORD_W'(ORIGIN_X);
        dy      = pix_y - COORD_W'(ORIGIN_Y);
        cx_full = dx >> CELL_SHIFT;
        cy_full = dy >> CELL_SHIFT;
        // Full-width compare so pixels far right/below never alias into the grid.
        in_x    = (pix_x >= COORD_W'(ORIGIN_X)) && (cx_full < COORD_W'(GRID_W));
        in_y    = (pix_y >= COORD_W'(ORIGIN_Y)) && (cy_full < COORD_W'(GRID_H));
        in_grid = in_x && in_y;
        cx      = cx_full[3:0];
        cy      = cy_full[3:0];
    end

endmodule

// File: rtl/battle_grid_engine.sv
// Two-board battleship engine: place/shoot/clear commands over valid/ready with
// one response pulse each, plus a registered pixel-to-cell lookup for rendering.
module battle_grid_engine
    import grid_pkg::*;
#(
    parameter int GRID_W     = 10,
    parameter int GRID_H     = 10,
    parameter int COORD_W    = 10,
    parameter int CELL_SHIFT = 5,
    parameter int ORIGIN_X   = 0,
    parameter int ORIGIN_Y   = 0,
    parameter int MAX_SHIP   = 5,
    parameter int CNT_W      = 7
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic               cmd_board,
    input  logic [3:0]         cmd_x,
    input  logic [3:0]         cmd_y,
    input  logic               cmd_dir,
    input  logic [2:0]         cmd_len,
    output logic               rsp_valid,
    output logic [2:0]         rsp_code,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic               pix_board,
    output logic [1:0]         pix_status,
    output logic               pix_in_grid,
    output logic [CNT_W-1:0]   ship_cells_p,
    output logic [CNT_W-1:0]   ship_cells_ia,
    output logic [CNT_W-1:0]   hits_p,
    output logic [CNT_W-1:0]   hits_ia,
    output logic               sunk_p,
    output logic               sunk_ia
);

    logic [1:0]       cells [2][GRID_H][GRID_W];
    logic [CNT_W-1:0] ship_cnt [2];
    logic [CNT_W-1:0] hit_cnt  [2];

    state_e     state;
    logic       board_q, dir_q;
    logic [3:0] x_q, y_q, i_q;
    logic [2:0] len_q;

    logic [3:0]     cur_x, cur_y;
    logic [1:0]     cur_cell;
    logic           last_i, len_bad, place_oob, coord_oob;
    logic [CNT_W:0] ship_sum;
    int             end_x, end_y;

    always_comb begin
        cur_x    = dir_q ? x_q : x_q + i_q;
        cur_y    = dir_q ? y_q + i_q : y_q;
        cur_cell = cells[board_q][cur_y][cur_x];
        last_i   = (i_q == ({1'b0, len_q} - 4'd1));
        ship_sum = {1'b0, ship_cnt[board_q]} + {{(CNT_W - 2){1'b0}}, len_q};

        len_bad   = (cmd_len == 3'd0) || (int'(cmd_len) > MAX_SHIP);
        coord_oob = (int'(cmd_x) >= GRID_W) || (int'(cmd_y) >= GRID_H);
        end_x     = int'(cmd_x) + (cmd_dir ? 0 : int'(cmd_len) - 1);
        end_y     = int'(cmd_y) + (cmd_dir ? int'(cmd_len) - 1 : 0);
        place_oob = coord_oob || (end_x >= GRID_W) || (end_y >= GRID_H);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state     <= StIdle;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_code  <= RspOk;
            board_q   <= 1'b0;
            dir_q     <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            i_q       <= '0;
            len_q     <= '0;
            for (int b = 0; b < 2; b++) begin
                ship_cnt[b] <= '0;
                hit_cnt[b]  <= '0;
                for (int r = 0; r < GRID_H; r++) begin
                    for (int c = 0; c < GRID_W; c++) cells[b][r][c] <= CellFree;
                end
            end
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        board_q   <= cmd_board;
                        dir_q     <= cmd_dir;
                        x_q       <= cmd_x;
                        y_q       <= cmd_y;
                        len_q     <= cmd_len;
                        i_q       <= '0;
                        unique case (op_e'(cmd_op))
                            OpNop: begin
                                state <= StResp; rsp_valid <= 1'b1; rsp_code <= RspOk;
                            end
                            OpPlace: begin
                                if (len_bad) begin
                                    state <= StResp; rsp_valid <= 1'b1; rsp_code <= RspBadlen;
                                end else if (place_oob) begin
                                    state <= StResp; rsp_valid <= 1'b1; rsp_code <= RspOob;
                                end else begin
                                    state <= StCheck;
                                end
                            end
                            OpShoot: begin
                                if (coord_oob) begin
                                    state <= StResp; rsp_valid <= 1'b1; rsp_code <= RspOob;
                                end else begin
                                    state <= StShoot;
                                end
                            end
                            OpClear: state <= StClear;
                        endcase
                    end
                end
                StCheck: begin
                    if (cur_cell != CellFree) begin
                        state <= StResp; rsp_valid <= 1'b1; rsp_code <= RspCollide;
                    end else if (last_i) begin
                        i_q   <= '0;
                        state <= StWrite;
                    end else begin
                        i_q <= i_q + 4'd1;
                    end
                end
                StWrite: begin
                    cells[board_q][cur_y][cur_x] <= CellShip;
                    if (last_i) begin
                        ship_cnt[board_q] <= ship_sum[CNT_W] ? '1 : ship_sum[CNT_W-1:0];
                        state <= StResp; rsp_valid <= 1'b1; rsp_code <= RspOk;
                    end else begin
                        i_q <= i_q + 4'd1;
                    end
                end
                StShoot: begin
                    state     <= StResp;
                    rsp_valid <= 1'b1;
                    if (cur_cell == CellShip) begin
                        cells[board_q][cur_y][cur_x] <= CellHit;
                        if (hit_cnt[board_q] != '1) hit_cnt[board_q] <= hit_cnt[board_q] + 1'b1;
                        rsp_code <= RspHit;
                    end else if (cur_cell == CellFree) begin
                        cells[board_q][cur_y][cur_x] <= CellMiss;
                        rsp_code <= RspMiss;
                    end else begin
                        rsp_code <= RspAlready;
                    end
                end
                StClear: begin
                    for (int c = 0; c < GRID_W; c++) cells[board_q][i_q][c] <= CellFree;
                    if (i_q == 4'(GRID_H - 1)) begin
                        ship_cnt[board_q] <= '0;
                        hit_cnt[board_q]  <= '0;
                        state <= StResp; rsp_valid <= 1'b1; rsp_code <= RspOk;
                    end else begin
                        i_q <= i_q + 4'd1;
                    end
                end
                StResp: begin
                    state     <= StIdle;
                    cmd_ready <= 1'b1;
                end
                default: state <= StIdle;
            endcase
        end
    end

    logic [3:0] pcx, pcy;
    logic       pin;

    grid_pix_map #(
        .COORD_W    (COORD_W),
        .CELL_SHIFT (CELL_SHIFT),
        .ORIGIN_X   (ORIGIN_X),
        .ORIGIN_Y   (ORIGIN_Y),
        .GRID_W     (GRID_W),
        .GRID_H     (GRID_H)
    ) u_pix_map (
        .pix_x   (pix_x),
        .pix_y   (pix_y),
        .cx      (pcx),
        .cy      (pcy),
        .in_grid (pin)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pix_status  <= CellFree;
            pix_in_grid <= 1'b0;
        end else begin
            pix_in_grid <= pin;
            pix_status  <= pin ? cells[pix_board][pcy][pcx] : CellFree;
        end
    end

    assign ship_cells_p  = ship_cnt[0];
    assign ship_cells_ia = ship_cnt[1];
    assign hits_p        = hit_cnt[0];
    assign hits_ia       = hit_cnt[1];
    assign sunk_p        = (ship_cnt[0] != '0) && (hit_cnt[0] == ship_cnt[0]);
    assign sunk_ia       = (ship_cnt[1] != '0) && (hit_cnt[1] == ship_cnt[1]);

endmodule

// File: tb/tb_battle_grid_engine.sv
// Directed bench for battle_grid_engine: commands, responses, latencies,
// counters and the render lookup checked against hand-computed values.
module tb_battle_grid_engine;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic       cmd_valid, cmd_ready, cmd_board, cmd_dir;
    logic [1:0] cmd_op;
    logic [3:0] cmd_x, cmd_y;
    logic [2:0] cmd_len;
    logic       rsp_valid;
    logic [2:0] rsp_code;
    logic [9:0] pix_x, pix_y;
    logic       pix_board;
    logic [1:0] pix_status;
    logic       pix_in_grid;
    logic [6:0] ship_cells_p, ship_cells_ia, hits_p, hits_ia;
    logic       sunk_p, sunk_ia;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_in = ~clk_in;

    battle_grid_engine dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_board     (cmd_board),
        .cmd_x         (cmd_x),
        .cmd_y         (cmd_y),
        .cmd_dir       (cmd_dir),
        .cmd_len       (cmd_len),
        .rsp_valid     (rsp_valid),
        .rsp_code      (rsp_code),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .pix_board     (pix_board),
        .pix_status    (pix_status),
        .pix_in_grid   (pix_in_grid),
        .ship_cells_p  (ship_cells_p),
        .ship_cells_ia (ship_cells_ia),
        .hits_p        (hits_p),
        .hits_ia       (hits_ia),
        .sunk_p        (sunk_p),
        .sunk_ia       (sunk_ia)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Issue one command; returns the response code and accept-to-response latency.
    task automatic send(input logic [1:0] op, input logic b, input int x, input int y,
                        input logic d, input int len, output int code, output int lat);
        int guard = 0;
        @(negedge clk_in);
        while (!cmd_ready && guard < 50) begin
            @(negedge clk_in);
            guard++;
        end
        cmd_op = op; cmd_board = b; cmd_x = 4'(x); cmd_y = 4'(y);
        cmd_dir = d; cmd_len = 3'(len); cmd_valid = 1'b1;
        @(negedge clk_in);
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk_in);
            lat++;
        end
        if (!rsp_valid) begin
            check_eq("rsp_timeout", 0, 1);
            code = -1;
        end else begin
            code = int'(rsp_code);
        end
    endtask

    task automatic read_cell(input logic b, input int x, input int y, output int st);
        pix_board = b;
        pix_x = 10'(x * 32 + 5);
        pix_y = 10'(y * 32 + 5);
        @(negedge clk_in);
        st = int'(pix_status);
    endtask

    initial begin
        int code, lat, st;
        bit saw_rsp;

        rst_n_in = 1'b0;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_board = 1'b0; cmd_x = '0; cmd_y = '0;
        cmd_dir = 1'b0; cmd_len = '0;
        pix_x = 10'd0; pix_y = 10'd0; pix_board = 1'b0;
        #23;
        check_eq("rst_cmd_ready", int'(cmd_ready), 1);
        check_eq("rst_rsp_valid", int'(rsp_valid), 0);
        check_eq("rst_rsp_code", int'(rsp_code), 0);
        check_eq("rst_pix_in_grid", int'(pix_in_grid), 0);
        check_eq("rst_ship_cells_p", int'(ship_cells_p), 0);
        rst_n_in = 1'b1;

        // Place a horizontal 3-ship at (2,3) on the player board.
        send(2'd1, 1'b0, 2, 3, 1'b0, 3, code, lat);
        check_eq("place_ok_code", code, 0);
        check_eq("place_ok_lat", lat, 7);
        @(negedge clk_in);
        check_eq("rsp_one_cycle", int'(rsp_valid), 0);
        check_eq("ship_cells_p_3", int'(ship_cells_p), 3);
        for (int x = 2; x <= 5; x++) begin
            read_cell(1'b0, x, 3, st);
            check_eq($sformatf("cell_%0d_3", x), st, (x <= 4) ? 1 : 0);
        end

        // Vertical 4-ship crossing the first ship at (3,3): collides on i=2.
        send(2'd1, 1'b0, 3, 1, 1'b1, 4, code, lat);
        check_eq("collide_code", code, 2);
        check_eq("collide_lat", lat, 4);
        read_cell(1'b0, 3, 1, st);
        check_eq("collide_cell_free", st, 0);
        check_eq("collide_cnt_same", int'(ship_cells_p), 3);

        send(2'd1, 1'b0, 8, 0, 1'b0, 3, code, lat);
        check_eq("oob_code", code, 1);
        check_eq("oob_lat", lat, 1);
        send(2'd1, 1'b0, 7, 0, 1'b0, 3, code, lat);
        check_eq("edge_fit_code", code, 0);
        send(2'd1, 1'b0, 0, 8, 1'b1, 3, code, lat);
        check_eq("oob_vert_code", code, 1);
        send(2'd1, 1'b0, 0, 0, 1'b0, 0, code, lat);
        check_eq("badlen0_code", code, 3);
        check_eq("badlen0_lat", lat, 1);
        send(2'd1, 1'b0, 0, 0, 1'b0, 6, code, lat);
        check_eq("badlen6_code", code, 3);
        check_eq("ship_cells_p_6", int'(ship_cells_p), 6);

        // Clear board 0 and rebuild only the first ship for the sink test.
        send(2'd3, 1'b0, 0, 0, 1'b0, 0, code, lat);
        check_eq("clear1_lat", lat, 11);
        send(2'd1, 1'b0, 2, 3, 1'b0, 3, code, lat);
        check_eq("replace_code", code, 0);

        send(2'd2, 1'b0, 2, 3, 1'b0, 0, code, lat);
        check_eq("shoot_hit_code", code, 4);
        check_eq("shoot_hit_lat", lat, 2);
        check_eq("hits_p_1", int'(hits_p), 1);
        send(2'd2, 1'b0, 2, 3, 1'b0, 0, code, lat);
        check_eq("shoot_already", code, 6);
        check_eq("hits_p_still_1", int'(hits_p), 1);
        send(2'd2, 1'b0, 0, 0, 1'b0, 0, code, lat);
        check_eq("shoot_miss", code, 5);
        read_cell(1'b0, 0, 0, st);
        check_eq("miss_cell", st, 2);
        send(2'd2, 1'b0, 0, 0, 1'b0, 0, code, lat);
        check_eq("shoot_miss_again", code, 6);
        send(2'd2, 1'b0, 10, 0, 1'b0, 0, code, lat);
        check_eq("shoot_oob", code, 1);
        check_eq("shoot_oob_lat", lat, 1);

        send(2'd2, 1'b0, 3, 3, 1'b0, 0, code, lat);
        check_eq("shoot_hit2", code, 4);
        check_eq("sunk_p_not_yet", int'(sunk_p), 0);
        send(2'd2, 1'b0, 4, 3, 1'b0, 0, code, lat);
        check_eq("shoot_hit3", code, 4);
        check_eq("hits_p_3", int'(hits_p), 3);
        check_eq("sunk_p", int'(sunk_p), 1);
        check_eq("sunk_ia", int'(sunk_ia), 0);

        // Render lookup: (70,100) -> cell (2,3), now HIT.
        pix_board = 1'b0; pix_x = 10'd70; pix_y = 10'd100;
        @(negedge clk_in);
        check_eq("pix_in_grid", int'(pix_in_grid), 1);
        check_eq("pix_status_hit", int'(pix_status), 3);
        pix_x = 10'd319;
        @(negedge clk_in);
        check_eq("pix_edge_in", int'(pix_in_grid), 1);
        pix_x = 10'd330;
        @(negedge clk_in);
        check_eq("pix_out_grid", int'(pix_in_grid), 0);
        check_eq("pix_out_status", int'(pix_status), 0);
        pix_board = 1'b1; pix_x = 10'd70;
        @(negedge clk_in);
        check_eq("pix_ia_free", int'(pix_status), 0);

        send(2'd0, 1'b0, 0, 0, 1'b0, 0, code, lat);
        check_eq("nop_code", code, 0);
        check_eq("nop_lat", lat, 1);

        send(2'd3, 1'b0, 0, 0, 1'b0, 0, code, lat);
        check_eq("clear_code", code, 0);
        check_eq("clear_lat", lat, 11);
        check_eq("clear_ship_cells", int'(ship_cells_p), 0);
        check_eq("clear_hits", int'(hits_p), 0);
        check_eq("clear_sunk", int'(sunk_p), 0);
        read_cell(1'b0, 2, 3, st);
        check_eq("clear_cell_2_3", st, 0);
        read_cell(1'b0, 0, 0, st);
        check_eq("clear_cell_0_0", st, 0);

        // Reset in the middle of the WRITE phase of a 5-long IA placement.
        @(negedge clk_in);
        cmd_op = 2'd1; cmd_board = 1'b1; cmd_x = 4'd0; cmd_y = 4'd0;
        cmd_dir = 1'b0; cmd_len = 3'd5; cmd_valid = 1'b1;
        @(negedge clk_in);
        cmd_valid = 1'b0;
        saw_rsp = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (rsp_valid) saw_rsp = 1'b1;
            @(negedge clk_in);
        end
        rst_n_in = 1'b0;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (rsp_valid) saw_rsp = 1'b1;
            @(negedge clk_in);
        end
        check_eq("abort_no_rsp", int'(saw_rsp), 0);
        check_eq("abort_cmd_ready", int'(cmd_ready), 1);
        check_eq("abort_ship_cells_ia", int'(ship_cells_ia), 0);
        for (int x = 0; x < 5; x++) begin
            read_cell(1'b1, x, 0, st);
            check_eq($sformatf("abort_cell_%0d", x), st, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
